// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types, widths and helpers for the signed 16/16 divider
package div_pkg;

    localparam int W     = 16;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Two's-complement negation at operand width.
    function automatic logic [W-1:0] neg_val(input logic [W-1:0] v);
        return (~v) + {{(W-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude as an unsigned value; the most negative input maps to 16'h8000.
    function automatic logic [W-1:0] abs_val(input logic [W-1:0] v);
        return v[W-1] ? neg_val(v) : v;
    endfunction

endpackage

// File: rtl/div_tc_16_16_step.sv
// rtl/div_tc_16_16_step.sv - one combinational restoring-division iteration
module div_step
    import div_pkg::*;
(
    input  logic [W:0]   i_rem,
    input  logic         i_bit,
    input  logic [W-1:0] i_mag_b,
    output logic [W:0]   o_rem,
    output logic         o_q_bit
);

    logic [W+1:0] w_shift;
    logic [W:0]   w_trial;
    logic         w_ge;

    // Shift in the next dividend bit, subtract the divisor and keep the result only if it did not go negative.
    always_comb begin
        w_shift = {i_rem, i_bit};
        w_ge    = (w_shift >= {2'b00, i_mag_b});
        w_trial = w_shift[W:0] - {1'b0, i_mag_b};
        o_rem   = w_ge ? w_trial : w_shift[W:0];
        o_q_bit = w_ge;
    end

endmodule

// File: rtl/div_tc_16_16.sv
// rtl/div_tc_16_16.sv - sequential signed 16/16 restoring divider with valid/ready handshakes
module div_tc_16_16
    import div_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_count;
    logic [W:0]         r_rem;
    logic [W-1:0]       r_qa;
    logic [W-1:0]       r_mag_b;
    logic [W-1:0]       r_dividend;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_dz;
    logic [W-1:0]       r_quotient;
    logic [W-1:0]       r_remainder;
    logic               r_div_by_zero;

    logic [W:0]         w_rem_next;
    logic               w_q_bit;

    // r_qa starts as |dividend| and its MSB feeds the step; quotient bits shift in at the LSB.
    div_step u_step (
        .i_rem   (r_rem),
        .i_bit   (r_qa[W-1]),
        .i_mag_b (r_mag_b),
        .o_rem   (w_rem_next),
        .o_q_bit (w_q_bit)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = CALC;
                end
            end
            CALC: begin
                if (r_count == CNT_W'(W - 1)) begin
                    w_state_next = FIX;
                end
            end
            FIX: begin
                w_state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and sign-corrected result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count       <= '0;
            r_rem         <= '0;
            r_qa          <= '0;
            r_mag_b       <= '0;
            r_dividend    <= '0;
            r_sign_q      <= 1'b0;
            r_sign_r      <= 1'b0;
            r_dz          <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign_q   <= dividend[W-1] ^ divisor[W-1];
                        r_sign_r   <= dividend[W-1];
                        r_qa       <= abs_val(dividend);
                        r_mag_b    <= abs_val(divisor);
                        r_dz       <= (divisor == '0);
                        r_dividend <= dividend;
                        r_rem      <= '0;
                        r_count    <= '0;
                    end
                end
                CALC: begin
                    r_rem   <= w_rem_next;
                    r_qa    <= {r_qa[W-2:0], w_q_bit};
                    r_count <= r_count + 1'b1;
                end
                FIX: begin
                    if (r_dz) begin
                        r_quotient    <= '1;
                        r_remainder   <= r_dividend;
                        r_div_by_zero <= 1'b1;
                    end else begin
                        r_quotient    <= r_sign_q ? neg_val(r_qa) : r_qa;
                        r_remainder   <= r_sign_r ? neg_val(r_rem[W-1:0]) : r_rem[W-1:0];
                        r_div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_div_tc_16_16.sv
// tb/tb_div_tc_16_16.sv - self-checking bench for div_tc_16_16
module tb_div_tc_16_16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int checks;
    int errors;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs[12];

    div_tc_16_16 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r, output logic dz);
        int ia;
        int ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        if (ib == 0) begin
            q  = 16'hFFFF;
            r  = a;
            dz = 1'b1;
        end else begin
            q  = 16'(ia / ib);
            r  = 16'(ia % ib);
            dz = 1'b0;
        end
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic edz,
                          input int stall);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({name, " latency"}, 32'(lat), 32'd17);
        repeat (stall) @(negedge clk);
        check({name, " quotient"}, 32'(quotient), 32'(eq));
        check({name, " remainder"}, 32'(remainder), 32'(er));
        check({name, " dz"}, 32'(div_by_zero), 32'(edz));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] mq;
        logic [15:0] mr;
        logic        mdz;
        int          seen;
        int          n;

        checks = 0;
        errors = 0;

        vecs[0]  = '{16'd100,   16'd7,      16'd14,   16'd2,    1'b0};
        vecs[1]  = '{16'hFF9C,  16'd7,      16'hFFF2, 16'hFFFE, 1'b0};
        vecs[2]  = '{16'd100,   16'hFFF9,   16'hFFF2, 16'd2,    1'b0};
        vecs[3]  = '{16'hFF9C,  16'hFFF9,   16'd14,   16'hFFFE, 1'b0};
        vecs[4]  = '{16'd1234,  16'd0,      16'hFFFF, 16'd1234, 1'b1};
        vecs[5]  = '{16'h8000,  16'hFFFF,   16'h8000, 16'd0,    1'b0};
        vecs[6]  = '{16'h8000,  16'd1,      16'h8000, 16'd0,    1'b0};
        vecs[7]  = '{16'd7,     16'd3,      16'd2,    16'd1,    1'b0};
        vecs[8]  = '{16'd0,     16'd5,      16'd0,    16'd0,    1'b0};
        vecs[9]  = '{16'h7FFF,  16'h8000,   16'd0,    16'h7FFF, 1'b0};
        vecs[10] = '{16'h8000,  16'h8000,   16'd1,    16'd0,    1'b0};
        vecs[11] = '{16'hFFFB,  16'd0,      16'hFFFF, 16'hFFFB, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        check("reset dz", 32'(div_by_zero), 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].q, vecs[i].r, vecs[i].dz, 0);
        end

        // Backpressure: 503 / -10 = -50 rem 3, held for 10 cycles with a competing in_valid.
        dividend = 16'd503;
        divisor  = 16'hFFF6;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        dividend = 16'd1;
        divisor  = 16'd1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp quotient", 32'(quotient), 32'hFFCE);
            check("bp remainder", 32'(remainder), 32'd3);
            check("bp dz", 32'(div_by_zero), 32'd0);
            check("bp in_ready", 32'(in_ready), 32'd0);
            check("bp hold valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp release in_ready", 32'(in_ready), 32'd1);
        check("bp release out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("bp no queued op", 32'(in_ready), 32'd1);

        // Reset in the middle of CALC discards the operation.
        dividend = 16'd1000;
        divisor  = 16'd3;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst quotient", 32'(quotient), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst no result", 32'(seen), 32'd0);
        check("midrst idle", 32'(in_ready), 32'd1);
        run_op("post rst 7/3", 16'd7, 16'd3, 16'd2, 16'd1, 1'b0, 0);

        // Random regression against a truncating signed-divide model.
        for (int k = 0; k < 1500; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 5))
                0: rb = 16'($urandom_range(0, 20));
                1: rb = 16'(-$urandom_range(0, 20));
                2: ra = 16'h8000;
                3: rb = 16'd0;
                default: ;
            endcase
            model(ra, rb, mq, mr, mdz);
            run_op($sformatf("rand%0d %h/%h", k, ra, rb), ra, rb, mq, mr, mdz,
                   int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
